stream_unpacker: RTL and testbench
==================================

// Module: stream_unpacker
// PURPOSE
//   Valid/ready stream width converter, wide to narrow. Accepts one N-element word
//   per src handshake and emits the elements one per dst handshake, element 0
//   (LSBs) first.
//   Output-side counterpart of the packing datapath under Top; sits between a wide
//   producer and a narrow consumer.
// PARAMETERS
//   IBW  8  bit width of one element
//   N    4  elements per input word (N>=2)
// PORTS
//   clk      in   1      clock; all state on posedge
//   rst      in   1      reset, asynchronous, active-low
//   src_val  in   1      input word valid
//   src_rdy  out  1      block can accept a word this cycle
//   src_dat  in   IBW*N  input word; element k = src_dat[k*IBW +: IBW]
//   dst_val  out  1      output element valid
//   dst_rdy  in   1      consumer accepts element this cycle
//   dst_dat  out  IBW    output element
//   dst_last out  1      last element of word (only with UNPACK_LAST_EN)
// BEHAVIOUR
//   - Clock and reset: single clock clk; rst is asynchronous, active-low.
//   - State:
//     - word register w[IBW*N]
//     - index idx[$clog2(N)]
//     - flag full
//   - Reset (rst=0, immediate): full=0, idx=0, w=0.
//     Outputs while in reset: dst_val=0, dst_dat=0, src_rdy=0, dst_last=0.
//   - Handshakes:
//     - A src transfer occurs when src_val&&src_rdy at posedge.
//     - A dst transfer occurs when dst_val&&dst_rdy at posedge.
//   - dst_val = full.
//   - dst_dat = w[idx*IBW +: IBW]. It is registered state, not a combinational path
//     from src_dat.
//   - src_rdy = rst && (!full || (idx==N-1 && dst_rdy)).
//     - Allows a new word to load in the same cycle the last element leaves.
//     - Gives sustained throughput of 1 element/cycle with zero bubbles.
//   - Latency: a word accepted at edge t presents element 0 from t (after the edge).
//     Element k is presented no earlier than t+k.
//   - dst transfer with idx<N-1: idx<=idx+1.
//   - dst transfer with idx==N-1: idx<=0.
//     - With a simultaneous src transfer: w<=src_dat and full stays 1.
//     - Without one: full<=0.
//   - src transfer while !full: w<=src_dat, full<=1, idx<=0.
//   - Backpressure: while dst_val && !dst_rdy, dst_dat and idx hold.
//     src_rdy=0 unless empty.
//   - src_dat is sampled only on a src transfer. It is ignored otherwise, including
//     when src_val=1 while src_rdy=0.
//   - Reset mid-word discards the remaining elements. After release, the first
//     element is element 0 of the next accepted word.
//   - dst_val must not drop without a dst transfer (AXI-style stability).
// CONFIGURATION
//   - UNPACK_LAST_EN defined:
//     - Adds port dst_last = full && idx==N-1.
//     - Reset value of dst_last is 0.
//   - UNPACK_LAST_EN undefined: dst_last port absent; all other behaviour identical.
// STRUCTURE
//   - Package stream_pkg:
//     - localparam IDX_W = $clog2(N)
//     - typedef logic [IBW-1:0] elem_t
//     - typedef elem_t [N-1:0] word_t (packed, element 0 at LSBs)
//   - No sub-module: element select is an indexed part-select.
//   - Control is the full flag plus idx; no separate FSM module.
// TESTING (IBW=8, N=4)
//   1. Single word: src 32'h44332211, dst_rdy=1 -> dst_dat 11,22,33,44 on 4
//      consecutive cycles, then dst_val=0.
//   2. Back-to-back: 32'h44332211 then 32'h88776655, src_val held, dst_rdy=1
//      -> 8 elements 11..88 with no gap.
//      src_rdy=1 exactly in the cycle element 44 is presented.
//   3. Backpressure: dst_rdy=0 for 3 cycles after element 11 is taken
//      -> dst_dat holds 22, dst_val=1, src_rdy=0 throughout.
//      Remaining order is 22,33,44.
//   4. src_val=1 with new word while element 22 is pending -> word not accepted
//      (src_rdy=0); the old word completes first.
//   5. Reset mid-word: rst=0 after 11,22 are taken -> dst_val=0 and src_rdy=0
//      immediately.
//      After release, src 32'hDDCCBBAA yields AA first; 33,44 are never emitted.
//   6. UNPACK_LAST_EN: case 2 -> dst_last=1 only with 44 and 88.
//      Without the macro the bench compiles with no dst_last port.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types for the wide-to-narrow stream unpacker.
// Element/word typedefs; element 0 sits at the word LSBs.
package stream_pkg;
  localparam int ELEM_W = 8;
  localparam int ELEMS  = 4;
  localparam int IDX_W  = $clog2(ELEMS);
  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [ELEMS-1:0] word_t;
endpackage

// File: rtl/stream_unpacker_if.sv
// Handshake bundle: wide src stream in, narrow dst stream out.
// slave = unpacker side, master = producer/consumer side.
// With UNPACK_LAST_EN defined, the bundle carries dst_last.
interface stream_unpacker_if #(
  parameter int IBW = 8,
  parameter int N   = 4
);
  logic             src_val;
  logic             src_rdy;
  logic [IBW*N-1:0] src_dat;
  logic             dst_val;
  logic             dst_rdy;
  logic [IBW-1:0]   dst_dat;
`ifdef UNPACK_LAST_EN
  logic             dst_last;

  modport slave (
    input  src_val, src_dat, dst_rdy,
    output src_rdy, dst_val, dst_dat, dst_last
  );
  modport master (
    output src_val, src_dat, dst_rdy,
    input  src_rdy, dst_val, dst_dat, dst_last
  );
`else
  modport slave (
    input  src_val, src_dat, dst_rdy,
    output src_rdy, dst_val, dst_dat
  );
  modport master (
    output src_val, src_dat, dst_rdy,
    input  src_rdy, dst_val, dst_dat
  );
`endif
endinterface

// File: rtl/stream_unpacker.sv
// Wide-to-narrow stream unpacker: one N-element word in, elements out LSB first.
// Ports: clk, rst (async active-low), io (stream_unpacker_if.slave). Macro: UNPACK_LAST_EN.
module stream_unpacker
  import stream_pkg::*;
#(
  parameter int IBW = ELEM_W,
  parameter int N   = ELEMS
) (
  input  logic clk,
  input  logic rst,
  stream_unpacker_if.slave io
);
  localparam int IW = $clog2(N);

  logic                    full_q, full_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N-1:0][IBW-1:0]   w_q, w_d;
  logic                    last;
  logic                    src_xfer;
  logic                    dst_xfer;

  assign last = (idx_q == IW'(N - 1));

  // A new word may load in the cycle the last element leaves.
  assign io.src_rdy = rst && (!full_q || (last && io.dst_rdy));
  assign io.dst_val = full_q;
  assign io.dst_dat = w_q[idx_q];
`ifdef UNPACK_LAST_EN
  assign io.dst_last = full_q && last;
`endif

  assign src_xfer = io.src_val && io.src_rdy;
  assign dst_xfer = full_q && io.dst_rdy;

  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    w_d    = w_q;
    if (dst_xfer) begin
      if (!last) begin
        idx_d = idx_q + 1'b1;
      end else begin
        idx_d  = '0;
        full_d = 1'b0;
      end
    end
    if (src_xfer) begin
      w_d    = io.src_dat;
      full_d = 1'b1;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      idx_q  <= '0;
      w_q    <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      w_q    <= w_d;
    end
  end
endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker (IBW=8, N=4).
// Directed scenarios plus a randomized run against a queue model.
module tb_stream_unpacker;
  import stream_pkg::*;

  logic clk;
  logic rst;
  int   errs;
  int   checks;
  elem_t mq[$];

  stream_unpacker_if #(.IBW(8), .N(4)) bus ();

  stream_unpacker #(.IBW(8), .N(4)) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sv, input word_t sd, input bit dr);
    bus.src_val = sv;
    bus.src_dat = sd;
    bus.dst_rdy = dr;
    #1;
  endtask

  // Model: queue of elements still owed from the current word.
  task automatic tick();
    bit acc;
    acc = bus.src_val && (mq.size() == 0 ||
          (mq.size() == 1 && bus.dst_rdy));
    if (mq.size() > 0 && bus.dst_rdy) void'(mq.pop_front());
    if (acc) begin
      word_t w;
      w = bus.src_dat;
      for (int k = 0; k < 4; k++) mq.push_back(w[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    mq.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (bus.dst_val !== 1'b0 || bus.src_rdy !== 1'b0 ||
        bus.dst_dat !== 8'h00) begin
      errs++;
      $display("FAIL reset_out got val=%b rdy=%b dat=%h want 0 0 00",
               bus.dst_val, bus.src_rdy, bus.dst_dat);
    end
`ifdef UNPACK_LAST_EN
    checks++;
    if (bus.dst_last !== 1'b0) begin
      errs++;
      $display("FAIL reset_last got %b want 0", bus.dst_last);
    end
`endif
    do_reset();
    checks++;
    if (bus.src_rdy !== 1'b1 || bus.dst_val !== 1'b0) begin
      errs++;
      $display("FAIL post_reset got rdy=%b val=%b want 1 0",
               bus.src_rdy, bus.dst_val);
    end
  endtask

  task automatic test_single();
    elem_t e;
    do_reset();
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, 32'h0BAD_F00D, 1'b1);
    for (int k = 0; k < 4; k++) begin
      e = elem_t'(8'h11 * (k + 1));
      checks++;
      if (bus.dst_val !== 1'b1 || bus.dst_dat !== e) begin
        errs++;
        $display("FAIL single_e%0d got val=%b dat=%h want 1 %h",
                 k, bus.dst_val, bus.dst_dat, e);
      end
      tick();
    end
    checks++;
    if (bus.dst_val !== 1'b0) begin
      errs++;
      $display("FAIL single_end got val=%b want 0", bus.dst_val);
    end
  endtask

  task automatic test_back_to_back();
    elem_t e;
    do_reset();
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 32'h88776655, 1'b1);
      e = elem_t'(8'h11 * (i + 1));
      checks++;
      if (bus.dst_val !== 1'b1 || bus.dst_dat !== e ||
          bus.src_rdy !== (i % 4 == 3)) begin
        errs++;
        $display("FAIL b2b_e%0d got val=%b dat=%h rdy=%b want 1 %h %b",
                 i, bus.dst_val, bus.dst_dat, bus.src_rdy, e, i % 4 == 3);
      end
`ifdef UNPACK_LAST_EN
      checks++;
      if (bus.dst_last !== (i % 4 == 3)) begin
        errs++;
        $display("FAIL b2b_last%0d got %b want %b",
                 i, bus.dst_last, i % 4 == 3);
      end
`endif
      tick();
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if (bus.dst_val !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end got val=%b want 0", bus.dst_val);
    end
  endtask

  // Stall after 11 is taken; sv=1 offers a competing word.
  task automatic stall_word(input bit sv, input string nm);
    elem_t e;
    do_reset();
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(sv, word_t'($urandom), 1'b0);
      checks++;
      if (bus.dst_val !== 1'b1 || bus.dst_dat !== 8'h22 ||
          bus.src_rdy !== 1'b0) begin
        errs++;
        $display("FAIL %s_hold%0d got val=%b dat=%h rdy=%b want 1 22 0",
                 nm, c, bus.dst_val, bus.dst_dat, bus.src_rdy);
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      e = elem_t'(8'h11 * (k + 1));
      checks++;
      if (bus.dst_val !== 1'b1 || bus.dst_dat !== e) begin
        errs++;
        $display("FAIL %s_e%0d got val=%b dat=%h want 1 %h",
                 nm, k, bus.dst_val, bus.dst_dat, e);
      end
      tick();
    end
    checks++;
    if (bus.dst_val !== 1'b0) begin
      errs++;
      $display("FAIL %s_end got val=%b want 0", nm, bus.dst_val);
    end
  endtask

  task automatic test_backpressure();
    stall_word(1'b0, "bp");
  endtask

  task automatic test_src_blocked();
    stall_word(1'b1, "blk");
  endtask

  task automatic test_reset_mid();
    elem_t e;
    do_reset();
    drive(1'b1, 32'h44332211, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (bus.dst_val !== 1'b0 || bus.src_rdy !== 1'b0) begin
      errs++;
      $display("FAIL rstmid got val=%b rdy=%b want 0 0",
               bus.dst_val, bus.src_rdy);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hDDCCBBAA, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      e = elem_t'(8'hAA + 8'h11 * k);
      checks++;
      if (bus.dst_val !== 1'b1 || bus.dst_dat !== e) begin
        errs++;
        $display("FAIL rstmid_e%0d got val=%b dat=%h want 1 %h",
                 k, bus.dst_val, bus.dst_dat, e);
      end
      tick();
    end
    checks++;
    if (bus.dst_val !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_end got val=%b want 0", bus.dst_val);
    end
  endtask

  task automatic test_random();
    bit    xv;
    bit    xr;
    elem_t xd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, word_t'($urandom),
            $urandom_range(0, 3) != 0);
      xv = mq.size() > 0;
      xr = mq.size() == 0 || (mq.size() == 1 && bus.dst_rdy);
      xd = xv ? mq[0] : bus.dst_dat;
      checks++;
      if (bus.dst_val !== xv || bus.src_rdy !== xr ||
          bus.dst_dat !== xd) begin
        errs++;
        $display("FAIL rand%0d got val=%b rdy=%b dat=%h want %b %b %h",
                 i, bus.dst_val, bus.src_rdy, bus.dst_dat, xv, xr, xd);
      end
`ifdef UNPACK_LAST_EN
      checks++;
      if (bus.dst_last !== (mq.size() == 1)) begin
        errs++;
        $display("FAIL rand_last%0d got %b want %b",
                 i, bus.dst_last, mq.size() == 1);
      end
`endif
      tick();
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b0;
    bus.src_val = 1'b0;
    bus.src_dat = '0;
    bus.dst_rdy = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_src_blocked();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
